// File: rtl/bwt_dram_req_arbiter.sv
// bwt_dram_req_arbiter: round-robin sharing of one occurrence-table DRAM port between BWT-extend lanes,
// with an in-order tag FIFO that routes each returned count bundle back to its issuing lane.
module bwt_dram_req_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int LANE_W          = 2,
    parameter int ADDR_W          = 32,
    parameter int RSP_W           = 768,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 4
) (
    input  logic                      Clk_32UI,
    input  logic                      reset_BWT_extend,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_k,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_l,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      stall,
    output logic                      DRAM_valid,
    output logic [ADDR_W-1:0]         addr_k,
    output logic [ADDR_W-1:0]         addr_l,
    input  logic                      DRAM_get,
    input  logic [RSP_W-1:0]          rsp_data_in,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [RSP_W-1:0]          rsp_data,
    output logic [CNT_W-1:0]          outstanding,
    output logic                      rsp_err
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);

    logic [LANE_W-1:0] ptr, grant, idx;
    logic              found, can_issue, accept, pop;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LANE_W-1:0] tag_mem [MAX_OUTSTANDING];

    always_comb begin
        grant = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + LANE_W'(i);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    // Grants are held off during reset so nothing is accepted while state is being cleared
    assign can_issue = ~reset_BWT_extend & ~stall & (outstanding < CNT_W'(MAX_OUTSTANDING)) & |req_valid;
    assign accept    = can_issue & found;
    assign req_ready = accept ? NUM_REQ'(1) << grant : '0;
    assign pop       = DRAM_get & (outstanding != '0);

    always_ff @(posedge Clk_32UI)
        if (accept) tag_mem[wr_ptr] <= grant;

    always_ff @(posedge Clk_32UI or posedge reset_BWT_extend)
        if (reset_BWT_extend) begin
            ptr         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            DRAM_valid  <= 1'b0;
            addr_k      <= '0;
            addr_l      <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            outstanding <= '0;
            rsp_err     <= 1'b0;
        end else begin
            DRAM_valid  <= accept;
            rsp_valid   <= pop ? NUM_REQ'(1) << tag_mem[rd_ptr] : '0;
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(pop);
            if (accept) begin
                ptr    <= grant + LANE_W'(1);
                wr_ptr <= wr_ptr + PTR_W'(1);
                addr_k <= req_addr_k[grant*ADDR_W +: ADDR_W];
                addr_l <= req_addr_l[grant*ADDR_W +: ADDR_W];
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                rsp_data <= rsp_data_in;
            end
            if (DRAM_get && !pop) rsp_err <= 1'b1;
        end
endmodule

// File: tb/tb_bwt_dram_req_arbiter.sv
// tb_bwt_dram_req_arbiter: directed plus random stimulus checked against a queue-based reference model.
module tb_bwt_dram_req_arbiter;
    localparam int N = 4, AW = 32, RW = 768, MAXO = 8, CW = 4;

    logic            clk, rst;
    logic [N-1:0]    req_valid, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr_k, req_addr_l;
    logic            stall, DRAM_valid, DRAM_get, rsp_err;
    logic [AW-1:0]   addr_k, addr_l;
    logic [RW-1:0]   rsp_data_in, rsp_data;
    logic [CW-1:0]   outstanding;

    bwt_dram_req_arbiter dut (
        .Clk_32UI(clk), .reset_BWT_extend(rst), .req_valid(req_valid), .req_addr_k(req_addr_k),
        .req_addr_l(req_addr_l), .req_ready(req_ready), .stall(stall), .DRAM_valid(DRAM_valid),
        .addr_k(addr_k), .addr_l(addr_l), .DRAM_get(DRAM_get), .rsp_data_in(rsp_data_in),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .outstanding(outstanding), .rsp_err(rsp_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int q[$];
    int ptr;
    logic          e_dv, e_err;
    logic [AW-1:0] e_ak, e_al;
    logic [N-1:0]  e_rv;
    logic [RW-1:0] e_rd;

    task automatic chk(input string tag, input logic [RW-1:0] o, input logic [RW-1:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, o, e);
        end
    endtask

    function automatic logic [RW-1:0] rnd_bundle();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic rnd_addrs();
        for (int i = 0; i < N; i++) begin
            req_addr_k[i*AW +: AW] = $urandom;
            req_addr_l[i*AW +: AW] = $urandom;
        end
    endtask

    task automatic model_reset();
        q.delete();
        ptr = 0; e_dv = 0; e_ak = 0; e_al = 0; e_rv = 0; e_rd = 0; e_err = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_dv"}, DRAM_valid, 0);
        chk({tag, "_ak"}, addr_k, 0);
        chk({tag, "_al"}, addr_l, 0);
        chk({tag, "_rv"}, rsp_valid, 0);
        chk({tag, "_rd"}, rsp_data, 0);
        chk({tag, "_out"}, outstanding, 0);
        chk({tag, "_err"}, rsp_err, 0);
    endtask

    // One clock: predict grant from the spec's rules, advance the model, compare registered outputs.
    task automatic step();
        int lane;
        bit can;
        logic [N-1:0] e_rdy;
        #1;
        can = !stall && q.size() < MAXO && req_valid != 0;
        lane = -1;
        e_rdy = 0;
        if (can)
            for (int k = 0; k < N; k++)
                if (lane < 0 && req_valid[(ptr + k) % N]) lane = (ptr + k) % N;
        if (can) e_rdy[lane] = 1'b1;
        chk("req_ready", req_ready, e_rdy);
        e_rv = 0;
        if (DRAM_get) begin
            if (q.size() > 0) begin
                e_rv[q.pop_front()] = 1'b1;
                e_rd = rsp_data_in;
            end else e_err = 1;
        end
        e_dv = can;
        if (can) begin
            q.push_back(lane);
            ptr = (lane + 1) % N;
            e_ak = req_addr_k[lane*AW +: AW];
            e_al = req_addr_l[lane*AW +: AW];
        end
        @(posedge clk);
        #1;
        chk("DRAM_valid", DRAM_valid, e_dv);
        chk("addr_k", addr_k, e_ak);
        chk("addr_l", addr_l, e_al);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_data", rsp_data, e_rd);
        chk("outstanding", outstanding, q.size());
        chk("rsp_err", rsp_err, e_err);
    endtask

    task automatic drain();
        req_valid = 0; stall = 0; DRAM_get = 1;
        while (q.size() > 0) begin
            rsp_data_in = rnd_bundle();
            step();
        end
        DRAM_get = 0;
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic mid_reset(input string tag);
        rst = 1;
        #1;
        chk_zero(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    logic [31:0] t3v [3];

    initial begin
        t3v = '{32'h0, 32'h4fd34fd3, 32'h1a3db452};
        rst = 1; req_valid = 4'b1111; stall = 0; DRAM_get = 0; rsp_data_in = 0;
        rnd_addrs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 0;

        // Lanes 0,1,2 continuously valid
        req_valid = 4'b0111;
        repeat (6) begin
            rnd_addrs();
            step();
        end

        // Lane 1 alone fills the in-flight limit
        drain();
        req_valid = 4'b0010;
        req_addr_k[1*AW +: AW] = 32'h6bfa2ffe;
        req_addr_l[1*AW +: AW] = 32'h05c96189;
        repeat (9) step();
        chk("t2_full", outstanding, 8);
        chk("t2_addr_k", addr_k, 32'h6bfa2ffe);
        DRAM_get = 1; rsp_data_in = rnd_bundle();
        step();
        chk("t2_rv", rsp_valid, 4'b0010);
        chk("t2_out", outstanding, 7);
        DRAM_get = 0;
        step();
        chk("t2_regrant", DRAM_valid, 1);

        // Three single-lane issues, then stalled responses
        drain();
        for (int k = 0; k < 3; k++) begin
            req_valid = 0;
            req_valid[k] = 1'b1;
            rnd_addrs();
            step();
        end
        stall = 1; req_valid = 4'b0111; DRAM_get = 1;
        for (int k = 0; k < 3; k++) begin
            rsp_data_in = rnd_bundle();
            rsp_data_in[31:0] = t3v[k];
            step();
            chk("t3_rv", rsp_valid, 4'b0001 << k);
            chk("t3_cnt_a0", rsp_data[31:0], t3v[k]);
            chk("t3_nodv", DRAM_valid, 0);
        end
        stall = 0; DRAM_get = 0;

        // Accept and pop in the same cycle at outstanding=3
        drain();
        req_valid = 4'b1000;
        repeat (3) step();
        DRAM_get = 1; rsp_data_in = rnd_bundle();
        step();
        chk("t4_out", outstanding, 3);
        chk("t4_rv", rsp_valid, 4'b1000);
        DRAM_get = 0;

        // Response with nothing in flight
        drain();
        DRAM_get = 1; rsp_data_in = rnd_bundle();
        step();
        chk("t5_err", rsp_err, 1);
        chk("t5_rv", rsp_valid, 0);
        chk("t5_out", outstanding, 0);
        DRAM_get = 0;
        repeat (3) step();
        chk("t5_sticky", rsp_err, 1);
        mid_reset("t5_rst");

        // Reset mid-stream with five in flight
        req_valid = 4'b0100;
        repeat (5) step();
        chk("t6_out", outstanding, 5);
        req_valid = 4'b1111;
        mid_reset("t6_rst");
        #1;
        chk("t6_first", req_ready, 4'b0001);
        step();

        // Random traffic
        repeat (600) begin
            req_valid = $urandom;
            stall = ($urandom % 4) == 0;
            DRAM_get = ($urandom % 100) < 45;
            rsp_data_in = rnd_bundle();
            rnd_addrs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bwt_dram_req_arbiter.md
Name: bwt_dram_req_arbiter

Overview:
Shares the single occurrence-table DRAM port between NUM_REQ BWT-extend query lanes.
- Arbitrates (addr_k, addr_l) requests round-robin.
- Limits outstanding requests to MAX_OUTSTANDING.
- Tags each issued request with its lane index in an in-order tag FIFO, so each returned cnt/cntl bundle goes back to the lane that issued it.
- Sits between the query lanes and the memory interface that drives DRAM_valid/addr_k/addr_l and returns DRAM_get plus count data.

Parameters:
NUM_REQ, 4, number of requesting lanes (power of 2, 2..8)
LANE_W, 2, log2(NUM_REQ)
ADDR_W, 32, width of addr_k / addr_l
RSP_W, 768, packed response width: {cntl_b3..b0, cntl_a3..a0, cnt_b3..b0, cnt_a3..a0}
MAX_OUTSTANDING, 8, tag FIFO depth and in-flight limit (power of 2)
CNT_W, 4, log2(MAX_OUTSTANDING)+1

Ports:
Clk_32UI  in  1  clock, all state on rising edge
reset_BWT_extend  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-lane request valid
req_addr_k  in  NUM_REQ*ADDR_W  lane i occupies bits [i*ADDR_W +: ADDR_W]
req_addr_l  in  NUM_REQ*ADDR_W  same packing as req_addr_k
req_ready  out  NUM_REQ  one-hot grant, combinational; request accepted when req_valid[i] & req_ready[i]
stall  in  1  memory side cannot take a request this cycle
DRAM_valid  out  1  registered request strobe to memory
addr_k  out  ADDR_W  registered request address k
addr_l  out  ADDR_W  registered request address l
DRAM_get  in  1  one response bundle present on rsp_data_in this cycle
rsp_data_in  in  RSP_W  packed response bundle
rsp_valid  out  NUM_REQ  registered one-hot response strobe to the owning lane
rsp_data  out  RSP_W  registered response bundle
outstanding  out  CNT_W  requests issued and not yet answered
rsp_err  out  1  sticky: DRAM_get arrived with tag FIFO empty

Behaviour:
- Reset (async, any cycle, including mid-transaction): all outputs 0, RR pointer 0, tag FIFO empty, outstanding 0, rsp_err 0. In-flight responses are discarded. The first DRAM_get after reset sets rsp_err.
- Issue condition, evaluated each cycle: can_issue = ~stall & (outstanding < MAX_OUTSTANDING) & |req_valid. When can_issue = 0, req_ready = 0.
- Grant: first lane with req_valid set, scanning ptr, ptr+1, ... mod NUM_REQ. req_ready is one-hot for that lane.
- On accept edge:
  - ptr <= grant+1 mod NUM_REQ.
  - DRAM_valid <= 1; addr_k/addr_l <= the granted lane's addresses.
  - Push grant index to the tag FIFO.
- With no accept: DRAM_valid <= 0 and addr_k/addr_l hold their value.
- Request latency: exactly 1 cycle from accept edge to DRAM_valid. DRAM_valid is never high for two cycles from one accept. Back-to-back accepts give continuous DRAM_valid.
- stall only gates new accepts. A DRAM_valid already registered is not retracted.
- Response, DRAM_get = 1 with FIFO non-empty:
  - Pop the head tag.
  - rsp_valid <= one-hot(tag); rsp_data <= rsp_data_in. Latency 1 cycle.
  - Responses return strictly in issue order; memory guarantees ordering.
- DRAM_get = 1 with FIFO empty: no pop, rsp_valid <= 0, rsp_err <= 1 (sticky until reset).
- DRAM_get = 0: rsp_valid <= 0, rsp_data holds.
- outstanding: +1 on accept, -1 on valid pop. Simultaneous accept and pop leaves it unchanged. Range 0..MAX_OUTSTANDING.
- Full boundary: at outstanding = MAX_OUTSTANDING no grant, even if a pop occurs the same cycle (the full check uses the registered count). Issue resumes the cycle after the pop.
- Tag FIFO: circular, LANE_W-bit entries, pointers of width log2(MAX_OUTSTANDING) wrap naturally. Simultaneous push and pop at any occupancy, including empty→push-only and full→pop-only, is legal and required.
- Inputs req_addr_*/req_valid are only sampled on accept. Lanes may drop req_valid without penalty.

Test Plan:
1. Reset then lanes 0,1,2 valid continuously, stall=0 → grants 0,1,2,0,1,2 on consecutive cycles. DRAM_valid high from the cycle after the first accept; addr_k matches the granted lane's value each cycle.
2. Lane 1 only, addr_k=32'h6bfa2ffe, addr_l=32'h05c96189, 8 accepts, no DRAM_get → outstanding reaches 8, req_ready=0 thereafter. One DRAM_get → rsp_valid=4'b0010 next cycle, outstanding=7, and the next grant occurs one cycle after the pop.
3. Three accepts (lanes 0,1,2), then stall=1 plus three DRAM_get with bundles whose cnt_a0 = 32'h0, 32'h4fd34fd3, 32'h1a3db452 → rsp_valid 0001, 0010, 0100 on consecutive cycles with matching rsp_data. No DRAM_valid while stall=1.
4. Accept and DRAM_get in the same cycle at outstanding=3 → outstanding stays 3; the response routes to the oldest tag.
5. DRAM_get with outstanding=0 → rsp_err=1, rsp_valid=0, outstanding stays 0. rsp_err stays 1 until reset_BWT_extend pulses.
6. Assert reset mid-stream with outstanding=5 → all outputs 0 immediately, without waiting for a clock edge. After release, the first grant goes to lane 0 when all lanes are valid.
